// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the pipeline-register layouts used by the decode slice.
// Bubble constants live here so every stage injects the same canonical nop.
package y86_pkg;

  localparam int WORD = 64;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  typedef struct packed {
    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic [3:0]      ra;
    logic [3:0]      rb;
    logic [WORD-1:0] valc;
    logic [WORD-1:0] valp;
  } d_reg_t;

  typedef struct packed {
    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic [3:0]      src_a;
    logic [3:0]      src_b;
    logic [3:0]      dst_e;
    logic [3:0]      dst_m;
    logic [WORD-1:0] val_a;
    logic [WORD-1:0] val_b;
    logic [WORD-1:0] val_c;
  } e_reg_t;

  localparam d_reg_t D_BUBBLE = '{icode: I_NOP, ifun: 4'h0, ra: RNONE, rb: RNONE,
                                  valc: 64'd0, valp: 64'd0};

  localparam e_reg_t E_BUBBLE = '{icode: I_NOP, ifun: 4'h0, src_a: RNONE, src_b: RNONE,
                                  dst_e: RNONE, dst_m: RNONE,
                                  val_a: 64'd0, val_b: 64'd0, val_c: 64'd0};

endpackage

// File: rtl/decode_logic.sv
// Combinational decode: register-id selection and the valA/valB forwarding muxes.
// Forwarding priority is execute, memory load, memory ALU, write-back load, write-back ALU.
module decode_logic
  import y86_pkg::*;
#(
  parameter int RF_REGS = 15
) (
  input  logic [3:0]              icode,
  input  logic [3:0]              ra,
  input  logic [3:0]              rb,
  input  logic [WORD-1:0]         valp,
  input  logic [3:0]              e_dst_e,
  input  logic [WORD-1:0]         e_val_e,
  input  logic [3:0]              m_dst_e,
  input  logic [WORD-1:0]         m_val_e,
  input  logic [3:0]              m_dst_m,
  input  logic [WORD-1:0]         m_val_m,
  input  logic [3:0]              w_dst_m,
  input  logic [WORD-1:0]         w_val_m,
  input  logic [3:0]              w_dst_e,
  input  logic [WORD-1:0]         w_val_e,
  input  logic [WORD*RF_REGS-1:0] rf_flat,
  output logic [3:0]              src_a,
  output logic [3:0]              src_b,
  output logic [3:0]              dst_e,
  output logic [3:0]              dst_m,
  output logic [WORD-1:0]         val_a,
  output logic [WORD-1:0]         val_b
);

  // Index 0 is the highest-priority forwarding source.
  logic [3:0]      fwd_dst [5];
  logic [WORD-1:0] fwd_val [5];

  assign fwd_dst = '{e_dst_e, m_dst_m, m_dst_e, w_dst_m, w_dst_e};
  assign fwd_val = '{e_val_e, m_val_m, m_val_e, w_val_m, w_val_e};

  function automatic logic [WORD-1:0] rf_read(input logic [WORD*RF_REGS-1:0] rf,
                                              input logic [3:0] idx);
    logic [WORD-1:0] r;
    r = '0;
    for (int i = 0; i < RF_REGS; i++)
      if (idx == 4'(i)) r = rf[i*WORD +: WORD];
    return r;
  endfunction

  // NOTE: every output gets a default first, so no path through this block can infer a latch.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    if (icode inside {I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ}) src_a = ra;
    else if (icode inside {I_RET, I_POPQ})                 src_a = RSP;
    if (icode inside {I_RMMOVQ, I_MRMOVQ, I_OPQ})          src_b = rb;
    else if (icode inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}) src_b = RSP;
    if (icode inside {I_RRMOVQ, I_IRMOVQ, I_OPQ})          dst_e = rb;
    else if (icode inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}) dst_e = RSP;
    if (icode inside {I_MRMOVQ, I_POPQ})                   dst_m = ra;
  end

  // Walk sources lowest priority first so the highest-priority match is the last writer.
  // A source with dst RNONE can only match src RNONE, which is overridden to zero below.
  always_comb begin
    val_a = rf_read(rf_flat, src_a);
    val_b = rf_read(rf_flat, src_b);
    for (int i = 4; i >= 0; i--) begin
      if (src_a == fwd_dst[i]) val_a = fwd_val[i];
      if (src_b == fwd_dst[i]) val_b = fwd_val[i];
    end
    if (src_a == RNONE) val_a = '0;
    if (src_b == RNONE) val_b = '0;
    if (icode inside {I_JXX, I_CALL}) val_a = valp;
  end

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode slice: F->D pipeline register, combinational decode with forwarding,
// and D->E pipeline register. Holds no architectural state.
module decode_stage
  import y86_pkg::*;
#(
  parameter int RF_REGS = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              f_icode,
  input  logic [3:0]              f_ifun,
  input  logic [3:0]              f_rA,
  input  logic [3:0]              f_rB,
  input  logic [WORD-1:0]         f_valC,
  input  logic [WORD-1:0]         f_valP,
  input  logic                    D_stall,
  input  logic                    D_bubble,
  input  logic                    E_bubble,
  input  logic [3:0]              e_dstE,
  input  logic [WORD-1:0]         e_valE,
  input  logic [3:0]              M_dstE,
  input  logic [WORD-1:0]         M_valE,
  input  logic [3:0]              M_dstM,
  input  logic [WORD-1:0]         m_valM,
  input  logic [3:0]              W_dstM,
  input  logic [WORD-1:0]         W_valM,
  input  logic [3:0]              W_dstE,
  input  logic [WORD-1:0]         W_valE,
  input  logic [WORD*RF_REGS-1:0] rf_flat,
  output logic [3:0]              D_icode,
  output logic [3:0]              D_ifun,
  output logic [3:0]              D_rA,
  output logic [3:0]              D_rB,
  output logic [WORD-1:0]         D_valC,
  output logic [WORD-1:0]         D_valP,
  output logic [3:0]              d_srcA,
  output logic [3:0]              d_srcB,
  output logic [3:0]              d_dstE,
  output logic [3:0]              d_dstM,
  output logic [3:0]              E_icode,
  output logic [3:0]              E_ifun,
  output logic [3:0]              E_srcA,
  output logic [3:0]              E_srcB,
  output logic [3:0]              E_dstE,
  output logic [3:0]              E_dstM,
  output logic [WORD-1:0]         E_valA,
  output logic [WORD-1:0]         E_valB,
  output logic [WORD-1:0]         E_valC
);

  d_reg_t          d_reg_q, d_reg_d;
  e_reg_t          e_reg_q, e_reg_d;
  logic [WORD-1:0] d_val_a, d_val_b;

  decode_logic #(.RF_REGS(RF_REGS)) u_decode_logic (
    .icode   (d_reg_q.icode),
    .ra      (d_reg_q.ra),
    .rb      (d_reg_q.rb),
    .valp    (d_reg_q.valp),
    .e_dst_e (e_dstE),
    .e_val_e (e_valE),
    .m_dst_e (M_dstE),
    .m_val_e (M_valE),
    .m_dst_m (M_dstM),
    .m_val_m (m_valM),
    .w_dst_m (W_dstM),
    .w_val_m (W_valM),
    .w_dst_e (W_dstE),
    .w_val_e (W_valE),
    .rf_flat (rf_flat),
    .src_a   (d_srcA),
    .src_b   (d_srcB),
    .dst_e   (d_dstE),
    .dst_m   (d_dstM),
    .val_a   (d_val_a),
    .val_b   (d_val_b)
  );

  // Bubble beats stall for D; E has no stall and simply loads a bubble or the decode result.
  always_comb begin
    d_reg_d = d_reg_q;
    if (D_bubble)
      d_reg_d = D_BUBBLE;
    else if (!D_stall)
      d_reg_d = '{icode: f_icode, ifun: f_ifun, ra: f_rA, rb: f_rB,
                  valc: f_valC, valp: f_valP};

    e_reg_d = '{icode: d_reg_q.icode, ifun: d_reg_q.ifun,
                src_a: d_srcA, src_b: d_srcB, dst_e: d_dstE, dst_m: d_dstM,
                val_a: d_val_a, val_b: d_val_b, val_c: d_reg_q.valc};
    if (E_bubble) e_reg_d = E_BUBBLE;
  end

  // NOTE: state registers use non-blocking assignments so both stages update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_reg_q <= D_BUBBLE;
      e_reg_q <= E_BUBBLE;
    end else begin
      d_reg_q <= d_reg_d;
      e_reg_q <= e_reg_d;
    end
  end

  assign D_icode = d_reg_q.icode;
  assign D_ifun  = d_reg_q.ifun;
  assign D_rA    = d_reg_q.ra;
  assign D_rB    = d_reg_q.rb;
  assign D_valC  = d_reg_q.valc;
  assign D_valP  = d_reg_q.valp;

  assign E_icode = e_reg_q.icode;
  assign E_ifun  = e_reg_q.ifun;
  assign E_srcA  = e_reg_q.src_a;
  assign E_srcB  = e_reg_q.src_b;
  assign E_dstE  = e_reg_q.dst_e;
  assign E_dstM  = e_reg_q.dst_m;
  assign E_valA  = e_reg_q.val_a;
  assign E_valB  = e_reg_q.val_b;
  assign E_valC  = e_reg_q.val_c;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases followed by randomized cycles,
// all compared against a behavioural pipeline model held in the bench.
module tb_decode_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   f_icode, f_ifun, f_rA, f_rB;
  logic [63:0]  f_valC, f_valP;
  logic         D_stall, D_bubble, E_bubble;
  logic [3:0]   e_dstE, M_dstE, M_dstM, W_dstM, W_dstE;
  logic [63:0]  e_valE, M_valE, m_valM, W_valM, W_valE;
  logic [959:0] rf_flat;
  logic [3:0]   D_icode, D_ifun, D_rA, D_rB;
  logic [63:0]  D_valC, D_valP;
  logic [3:0]   d_srcA, d_srcB, d_dstE, d_dstM;
  logic [3:0]   E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM;
  logic [63:0]  E_valA, E_valB, E_valC;

  logic [63:0]  rf [15];

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < 15; i++) rf_flat[64*i +: 64] = rf[i];

  decode_stage dut (
    .clk(clk), .reset(reset),
    .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP),
    .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM), .W_dstM(W_dstM), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_valE(W_valE), .rf_flat(rf_flat),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
  } d_t;

  typedef struct {
    logic [3:0]  icode, ifun, srca, srcb, dste, dstm;
    logic [63:0] vala, valb, valc;
  } e_t;

  d_t md;
  e_t me;
  bit md_ok = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic d_t d_bubble_val();
    d_t d;
    d.icode = 4'h1; d.ifun = 4'h0; d.ra = 4'hF; d.rb = 4'hF; d.valc = 0; d.valp = 0;
    return d;
  endfunction

  function automatic e_t e_bubble_val();
    e_t e;
    e.icode = 4'h1; e.ifun = 4'h0;
    e.srca = 4'hF; e.srcb = 4'hF; e.dste = 4'hF; e.dstm = 4'hF;
    e.vala = 0; e.valb = 0; e.valc = 0;
    return e;
  endfunction

  function automatic logic [3:0] ref_src_a(d_t d);
    if (d.icode inside {4'h2, 4'h4, 4'h6, 4'hA}) return d.ra;
    if (d.icode inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] ref_src_b(d_t d);
    if (d.icode inside {4'h4, 4'h5, 4'h6}) return d.rb;
    if (d.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] ref_dst_e(d_t d);
    if (d.icode inside {4'h2, 4'h3, 4'h6}) return d.rb;
    if (d.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] ref_dst_m(d_t d);
    if (d.icode inside {4'h5, 4'hB}) return d.ra;
    return 4'hF;
  endfunction

  // Priority list scanned in order; first usable match wins, else the register file.
  function automatic logic [63:0] ref_operand(logic [3:0] src);
    logic [3:0]  dst [5];
    logic [63:0] val [5];
    dst = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    val = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (src == 4'hF) return 64'd0;
    for (int i = 0; i < 5; i++)
      if (dst[i] != 4'hF && dst[i] == src) return val[i];
    return rf[src];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    reset = 0; D_stall = 0; D_bubble = 0; E_bubble = 0;
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstM = 4'hF; W_dstE = 4'hF;
    e_valE = 0; M_valE = 0; m_valM = 0; W_valM = 0; W_valE = 0;
  endtask

  task automatic set_f(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp);
    f_icode = ic; f_ifun = fn; f_rA = ra; f_rB = rb; f_valC = vc; f_valP = vp;
  endtask

  // One clock: inputs already driven (called just after a falling edge).
  task automatic step();
    d_t nd;
    e_t ne;
    #1;
    if (md_ok) begin
      check("d_srcA", d_srcA, ref_src_a(md));
      check("d_srcB", d_srcB, ref_src_b(md));
      check("d_dstE", d_dstE, ref_dst_e(md));
      check("d_dstM", d_dstM, ref_dst_m(md));
    end
    ne.icode = md.icode; ne.ifun = md.ifun;
    ne.srca = ref_src_a(md); ne.srcb = ref_src_b(md);
    ne.dste = ref_dst_e(md); ne.dstm = ref_dst_m(md);
    ne.vala = (md.icode inside {4'h7, 4'h8}) ? md.valp : ref_operand(ne.srca);
    ne.valb = ref_operand(ne.srcb);
    ne.valc = md.valc;
    if (reset || E_bubble) ne = e_bubble_val();
    if (reset || D_bubble) nd = d_bubble_val();
    else if (D_stall)      nd = md;
    else begin
      nd.icode = f_icode; nd.ifun = f_ifun; nd.ra = f_rA; nd.rb = f_rB;
      nd.valc = f_valC; nd.valp = f_valP;
    end
    @(posedge clk);
    #1;
    if (reset) md_ok = 1;
    md = nd;
    me = ne;
    if (md_ok) begin
      check("D_icode", D_icode, md.icode);
      check("D_ifun",  D_ifun,  md.ifun);
      check("D_rA",    D_rA,    md.ra);
      check("D_rB",    D_rB,    md.rb);
      check("D_valC",  D_valC,  md.valc);
      check("D_valP",  D_valP,  md.valp);
      check("E_icode", E_icode, me.icode);
      check("E_ifun",  E_ifun,  me.ifun);
      check("E_srcA",  E_srcA,  me.srca);
      check("E_srcB",  E_srcB,  me.srcb);
      check("E_dstE",  E_dstE,  me.dste);
      check("E_dstM",  E_dstM,  me.dstm);
      check("E_valA",  E_valA,  me.vala);
      check("E_valB",  E_valB,  me.valb);
      check("E_valC",  E_valC,  me.valc);
    end
    @(negedge clk);
  endtask

  function automatic logic [3:0] rand_reg();
    return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 6));
  endfunction

  initial begin
    set_idle();
    set_f(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) rf[i] = 64'h1000 + 64'(i);
    @(negedge clk);

    // Reset, then release with fetch inputs at zero.
    reset = 1;
    step();
    check("rst_D_icode", D_icode, 64'h1);
    check("rst_D_rA",    D_rA,    64'hF);
    check("rst_E_icode", E_icode, 64'h1);
    check("rst_E_valA",  E_valA,  64'h0);
    check("rst_E_dstE",  E_dstE,  64'hF);
    reset = 0;
    step();

    // OPq with register-file operands.
    rf[2] = 10; rf[3] = 20;
    set_f(4'h6, 4'h0, 4'h2, 4'h3, 0, 64'h2);
    step();
    set_f(4'h1, 0, 4'hF, 4'hF, 0, 0);
    step();
    check("opq_valA", E_valA, 64'd10);
    check("opq_valB", E_valB, 64'd20);
    check("opq_dstE", E_dstE, 64'h3);
    check("opq_dstM", E_dstM, 64'hF);

    // Execute forwarding beats write-back forwarding.
    set_f(4'h6, 4'h0, 4'h2, 4'h3, 0, 64'h2);
    step();
    set_f(4'h1, 0, 4'hF, 4'hF, 0, 0);
    e_dstE = 4'h2; e_valE = 99; W_dstE = 4'h2; W_valE = 7;
    step();
    check("fwd_e_over_w", E_valA, 64'd99);
    set_idle();

    // Memory-load forwarding on srcB.
    set_f(4'h6, 4'h0, 4'h2, 4'h3, 0, 64'h2);
    step();
    set_f(4'h1, 0, 4'hF, 4'hF, 0, 0);
    M_dstM = 4'h3; m_valM = 55;
    step();
    check("fwd_m_valB", E_valB, 64'd55);
    set_idle();

    // call: valA takes valP, valB reads %rsp.
    rf[4] = 64'h100;
    set_f(4'h8, 0, 4'hF, 4'hF, 64'h77, 64'h40);
    step();
    check("call_srcB", d_srcB, 64'h4);
    set_f(4'h1, 0, 4'hF, 4'hF, 0, 0);
    step();
    check("call_valA", E_valA, 64'h40);
    check("call_valB", E_valB, 64'h100);
    check("call_dstE", E_dstE, 64'h4);

    // popq / mrmovq register selection.
    set_f(4'hB, 0, 4'h5, 4'hF, 0, 0);
    step();
    check("popq_srcA", d_srcA, 64'h4);
    check("popq_srcB", d_srcB, 64'h4);
    check("popq_dstE", d_dstE, 64'h4);
    check("popq_dstM", d_dstM, 64'h5);
    set_f(4'h5, 0, 4'h1, 4'h6, 64'h8, 0);
    step();
    check("mrm_srcA", d_srcA, 64'hF);
    check("mrm_srcB", d_srcB, 64'h6);
    check("mrm_dstM", d_dstM, 64'h1);

    // Load/use: D holds while E takes a bubble, then the held instruction proceeds.
    set_f(4'h6, 4'h3, 4'h2, 4'h3, 64'h5, 64'h9);
    step();
    set_f(4'h3, 0, 4'hF, 4'h7, 64'h123, 64'hA);
    D_stall = 1; E_bubble = 1;
    step();
    check("stall_D_icode", D_icode, 64'h6);
    check("stall_D_ifun",  D_ifun,  64'h3);
    check("stall_E_icode", E_icode, 64'h1);
    D_stall = 0; E_bubble = 0;
    step();
    check("held_E_icode", E_icode, 64'h6);
    check("held_E_ifun",  E_ifun,  64'h3);
    check("next_D_icode", D_icode, 64'h3);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      set_f(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rand_reg(), rand_reg(),
            {$urandom, $urandom}, {$urandom, $urandom});
      reset    = ($urandom_range(0, 39) == 0);
      D_bubble = ($urandom_range(0, 9) == 0);
      D_stall  = ($urandom_range(0, 5) == 0);
      E_bubble = ($urandom_range(0, 7) == 0);
      e_dstE = rand_reg(); M_dstE = rand_reg(); M_dstM = rand_reg();
      W_dstM = rand_reg(); W_dstE = rand_reg();
      e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
      m_valM = {$urandom, $urandom}; W_valM = {$urandom, $urandom};
      W_valE = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 14)] = {$urandom, $urandom};
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
